// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control sequencer for the MIPS-subset datapath: steps fetch, decode,
// execute, memory and writeback, with memory-ready waits, timeout abort and retirement count.
module multicycle_control_fsm #(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             memReady,
    output logic             pcEn,
    output logic             pcWrite,
    output logic             pcWriteCond,
    output logic             iOrD,
    output logic             memRead,
    output logic             memWrite,
    output logic             irWrite,
    output logic             memToReg,
    output logic             regDst,
    output logic             regWrite,
    output logic             aluSrcA,
    output logic [1:0]       aluSrcB,
    output logic [1:0]       aluOp,
    output logic [1:0]       pcSource,
    output logic [3:0]       stateOut,
    output logic             instrDone,
    output logic             illegalOp,
    output logic             memTimeout,
    output logic [CNT_W-1:0] instrCount
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    localparam logic [7:0] LP_WAIT_MAX = 8'(WAIT_LIMIT - 1);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_wait;
    logic       w_wait_st;
    logic       w_expire;

    assign w_wait_st = (r_state == S_FETCH) || (r_state == S_MEM_READ) || (r_state == S_MEM_WRITE);
    assign w_expire  = w_wait_st && !memReady && (r_wait == LP_WAIT_MAX);

    // Outputs are a pure decode of state and inputs; reset blanks them without waiting for a clock.
    always_comb begin
        w_next      = r_state;
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        iOrD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        irWrite     = 1'b0;
        memToReg    = 1'b0;
        regDst      = 1'b0;
        regWrite    = 1'b0;
        aluSrcA     = 1'b0;
        aluSrcB     = 2'b00;
        aluOp       = 2'b00;
        pcSource    = 2'b00;
        instrDone   = 1'b0;
        illegalOp   = 1'b0;
        memTimeout  = 1'b0;
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    memRead = 1'b1;
                    aluSrcB = 2'b01;
                    irWrite = memReady;
                    pcWrite = memReady;
                    if (memReady) w_next = S_DECODE;
                end
                S_DECODE: begin
                    aluSrcB = 2'b11;
                    case (opcode)
                        6'b100011, 6'b101011: w_next = S_MEM_ADDR;
                        6'b000000:            w_next = S_EXECUTE;
                        6'b000100:            w_next = S_BRANCH;
                        6'b000010:            w_next = S_JUMP;
                        6'b001000:            w_next = S_ADDI_EXEC;
                        default: begin
                            w_next    = S_FETCH;
                            illegalOp = 1'b1;
                        end
                    endcase
                end
                S_MEM_ADDR: begin
                    aluSrcA = 1'b1;
                    aluSrcB = 2'b10;
                    w_next  = (opcode == 6'b100011) ? S_MEM_READ : S_MEM_WRITE;
                end
                S_MEM_READ: begin
                    memRead = 1'b1;
                    iOrD    = 1'b1;
                    if (memReady) w_next = S_MEM_WB;
                end
                S_MEM_WB: begin
                    memToReg  = 1'b1;
                    regWrite  = 1'b1;
                    instrDone = 1'b1;
                    w_next    = S_FETCH;
                end
                S_MEM_WRITE: begin
                    memWrite = 1'b1;
                    iOrD     = 1'b1;
                    if (memReady) begin
                        instrDone = 1'b1;
                        w_next    = S_FETCH;
                    end
                end
                S_EXECUTE: begin
                    aluSrcA = 1'b1;
                    aluOp   = 2'b10;
                    w_next  = S_R_WB;
                end
                S_R_WB: begin
                    regDst    = 1'b1;
                    regWrite  = 1'b1;
                    instrDone = 1'b1;
                    w_next    = S_FETCH;
                end
                S_BRANCH: begin
                    aluSrcA     = 1'b1;
                    aluOp       = 2'b01;
                    pcSource    = 2'b01;
                    pcWriteCond = 1'b1;
                    instrDone   = 1'b1;
                    w_next      = S_FETCH;
                end
                S_JUMP: begin
                    pcSource  = 2'b10;
                    pcWrite   = 1'b1;
                    instrDone = 1'b1;
                    w_next    = S_FETCH;
                end
                S_ADDI_EXEC: begin
                    aluSrcA = 1'b1;
                    aluSrcB = 2'b10;
                    w_next  = S_ADDI_WB;
                end
                S_ADDI_WB: begin
                    regWrite  = 1'b1;
                    instrDone = 1'b1;
                    w_next    = S_FETCH;
                end
                default: w_next = S_FETCH;
            endcase
            if (w_expire) begin
                memTimeout = 1'b1;
                w_next     = S_FETCH;
            end
        end
    end

    assign pcEn     = pcWrite | (pcWriteCond & zero);
    assign stateOut = reset ? 4'd0 : r_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_wait     <= 8'd0;
            instrCount <= '0;
        end else begin
            r_state <= w_next;
            // Any state change (including a FETCH retry) starts a fresh wait window.
            if ((w_next != r_state) || w_expire)
                r_wait <= 8'd0;
            else if (w_wait_st && !memReady)
                r_wait <= r_wait + 8'd1;
            if (instrDone)
                instrCount <= instrCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm: an instruction-level model queues the
// expected per-cycle outputs and a negedge monitor pops and compares them.
module tb_multicycle_control_fsm;

    localparam int WL = 4;

    localparam int S_F   = 0;
    localparam int S_D   = 1;
    localparam int S_MA  = 2;
    localparam int S_MR  = 3;
    localparam int S_MWB = 4;
    localparam int S_MWR = 5;
    localparam int S_EX  = 6;
    localparam int S_RWB = 7;
    localparam int S_BR  = 8;
    localparam int S_J   = 9;
    localparam int S_AE  = 10;
    localparam int S_AW  = 11;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        zero;
    logic        memReady;
    logic        pcEn, pcWrite, pcWriteCond, iOrD, memRead, memWrite, irWrite;
    logic        memToReg, regDst, regWrite, aluSrcA;
    logic [1:0]  aluSrcB, aluOp, pcSource;
    logic [3:0]  stateOut;
    logic        instrDone, illegalOp, memTimeout;
    logic [31:0] instrCount;

    multicycle_control_fsm #(.WAIT_LIMIT(WL), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .memReady(memReady),
        .pcEn(pcEn), .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iOrD(iOrD),
        .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite), .memToReg(memToReg),
        .regDst(regDst), .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
        .aluOp(aluOp), .pcSource(pcSource), .stateOut(stateOut), .instrDone(instrDone),
        .illegalOp(illegalOp), .memTimeout(memTimeout), .instrCount(instrCount)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  st;
        logic [16:0] ctl;
        logic [2:0]  pulse;
        logic [31:0] cnt;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_cnt    = 0;
    logic [16:0] act_ctl;

    assign act_ctl = {pcEn, pcWrite, pcWriteCond, iOrD, memRead, memWrite, irWrite, memToReg,
                      regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSource};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [16:0] exp_ctl(input int st, input bit rdy, input bit z);
        logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa;
        logic [1:0] asb, aop, psrc;
        {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa} = '0;
        {asb, aop, psrc} = '0;
        case (st)
            S_F:   begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; end
            S_D:   asb = 2'b11;
            S_MA:  begin asa = 1; asb = 2'b10; end
            S_MR:  begin mr = 1; iod = 1; end
            S_MWB: begin m2r = 1; rw = 1; end
            S_MWR: begin mw = 1; iod = 1; end
            S_EX:  begin asa = 1; aop = 2'b10; end
            S_RWB: begin rd = 1; rw = 1; end
            S_BR:  begin asa = 1; aop = 2'b01; psrc = 2'b01; pwc = 1; end
            S_J:   begin psrc = 2'b10; pw = 1; end
            S_AE:  begin asa = 1; asb = 2'b10; end
            S_AW:  rw = 1;
            default: ;
        endcase
        return {pw | (pwc & z), pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc};
    endfunction

    function automatic logic [5:0] junk();
        return 6'($urandom);
    endfunction

    // One clock cycle: drive inputs, queue what the DUT must show, advance.
    task automatic cyc(input int st, input logic [5:0] op, input bit rdy, input bit z,
                       input bit done, input bit ill, input bit tmo);
        exp_t e;
        opcode   = op;
        memReady = rdy;
        zero     = z;
        e.st     = 4'(st);
        e.ctl    = exp_ctl(st, rdy, z);
        e.pulse  = {done, ill, tmo};
        e.cnt    = m_cnt;
        q.push_back(e);
        if (done) m_cnt = m_cnt + 1;
        @(posedge clk);
        #1;
    endtask

    // A memory-wait state: nz_in low cycles of memReady pending, aborts after WL lows in a row.
    task automatic wait_phase(input int st, input int nz_in, output int nz_out, output bit ok);
        int waited = 0;
        int left   = nz_in;
        bit rdy, tmo;
        ok = 0;
        forever begin
            rdy = (left == 0);
            tmo = !rdy && (waited == WL - 1);
            cyc(st, junk(), rdy, 1'($urandom), rdy && (st == S_MWR), 1'b0, tmo);
            if (rdy) begin
                ok = 1;
                break;
            end
            left--;
            if (tmo) break;
            waited++;
        end
        nz_out = left;
    endtask

    // kind: 0 lw, 1 sw, 2 R-type, 3 beq, 4 j, 5 addi, 6 illegal
    task automatic run_instr(input int kind, input int nz_f, input int nz_m, input bit zb);
        logic [5:0] op;
        int         left;
        bit         ok;
        case (kind)
            0: op = 6'b100011;
            1: op = 6'b101011;
            2: op = 6'b000000;
            3: op = 6'b000100;
            4: op = 6'b000010;
            5: op = 6'b001000;
            default: begin
                do op = junk();
                while (op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
                       op == 6'b000100 || op == 6'b000010 || op == 6'b001000);
            end
        endcase
        left = nz_f;
        do wait_phase(S_F, left, left, ok);
        while (!ok);
        cyc(S_D, op, 1'($urandom), 1'($urandom), 1'b0, kind == 6, 1'b0);
        case (kind)
            0: begin
                cyc(S_MA, op, 1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0);
                wait_phase(S_MR, nz_m, left, ok);
                if (ok) cyc(S_MWB, junk(), 1'($urandom), 1'($urandom), 1'b1, 1'b0, 1'b0);
            end
            1: begin
                cyc(S_MA, op, 1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0);
                wait_phase(S_MWR, nz_m, left, ok);
            end
            2: begin
                cyc(S_EX, junk(), 1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0);
                cyc(S_RWB, junk(), 1'($urandom), 1'($urandom), 1'b1, 1'b0, 1'b0);
            end
            3: cyc(S_BR, junk(), 1'($urandom), zb, 1'b1, 1'b0, 1'b0);
            4: cyc(S_J, junk(), 1'($urandom), 1'($urandom), 1'b1, 1'b0, 1'b0);
            5: begin
                cyc(S_AE, junk(), 1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0);
                cyc(S_AW, junk(), 1'($urandom), 1'($urandom), 1'b1, 1'b0, 1'b0);
            end
            default: ;
        endcase
    endtask

    function automatic int rnd_wait();
        return ($urandom_range(0, 9) > 6) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 1));
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("state", 64'(stateOut), 64'(e.st));
            chk("controls", 64'(act_ctl), 64'(e.ctl));
            chk("pulses{done,ill,tmo}", 64'({instrDone, illegalOp, memTimeout}), 64'(e.pulse));
            chk("instrCount", 64'(instrCount), 64'(e.cnt));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        opcode   = 6'b100011;
        zero     = 1'b1;
        memReady = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 64'({act_ctl, instrDone, illegalOp, memTimeout, stateOut}), 64'd0);
        chk("reset_count", 64'(instrCount), 64'd0);
        reset = 1'b0;

        run_instr(0, 0, 0, 1'b0);
        run_instr(1, 0, 3, 1'b0);
        run_instr(3, 0, 0, 1'b1);
        run_instr(3, 0, 0, 1'b0);
        run_instr(6, 0, 0, 1'b0);
        run_instr(0, 0, 4, 1'b0);
        run_instr(2, 0, 0, 1'b0);
        run_instr(1, 0, 6, 1'b0);
        run_instr(5, 5, 0, 1'b0);
        run_instr(4, 3, 0, 1'b0);

        repeat (80) run_instr(int'($urandom_range(0, 6)), rnd_wait(), rnd_wait(), 1'($urandom));

        // Abandon an R-type in EXECUTE with an asynchronous reset.
        run_instr(4, 0, 0, 1'b0);
        cyc(S_F, junk(), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(S_D, 6'b000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        opcode   = junk();
        memReady = 1'b1;
        #1;
        chk("in_execute", 64'(stateOut), 64'(S_EX));
        #1 reset = 1'b1;
        #1;
        chk("async_reset_outputs", 64'({act_ctl, instrDone, illegalOp, memTimeout, stateOut}), 64'd0);
        chk("async_reset_count", 64'(instrCount), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_cnt = 0;

        repeat (15) run_instr(int'($urandom_range(0, 6)), rnd_wait(), rnd_wait(), 1'($urandom));

        @(negedge clk);
        #1;
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multi-cycle control sequencer for the MIPS-subset Processor datapath.
- Decodes the 6-bit opcode latched in the instruction register.
- Steps the shared ALU, register file and unified memory through Fetch, Decode, Execute, Memory and Writeback.
- Waits on a memory-ready handshake, aborts on memory timeout, and reports retirement (instrDone/instrCount) for the bench's register-trace monitor.

Parameters:
WAIT_LIMIT, 15, max consecutive cycles with memReady low in a memory-wait state before abort (1..255)
CNT_W, 32, width of instrCount

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high
opcode  input  6  instruction[31:26] from IR
zero  input  1  ALU zero flag
memReady  input  1  memory access completes this cycle
pcEn  output  1  PC load = pcWrite | (pcWriteCond & zero)
pcWrite  output  1  unconditional PC write
pcWriteCond  output  1  branch PC write
iOrD  output  1  0=PC addresses memory, 1=ALUOut
memRead  output  1  memory read strobe
memWrite  output  1  memory write strobe
irWrite  output  1  IR load
memToReg  output  1  1=MDR to register write data
regDst  output  1  1=rd, 0=rt
regWrite  output  1  register file write
aluSrcA  output  1  0=PC, 1=A
aluSrcB  output  2  00=B, 01=4, 10=signext imm, 11=imm<<2
aluOp  output  2  00=add, 01=sub, 10=funct
pcSource  output  2  00=ALU, 01=ALUOut, 10=jump target
stateOut  output  4  current state encoding
instrDone  output  1  one-cycle pulse on instruction retirement
illegalOp  output  1  one-cycle pulse for unknown opcode
memTimeout  output  1  one-cycle pulse on wait abort
instrCount  output  CNT_W  retired instruction count

Behaviour:
- States and encodings:
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11.
  - Codes 12-15 are unreachable; if entered, the FSM goes to FETCH next edge.
- Reset:
  - async reset forces state=FETCH, instrCount=0, wait counter=0.
  - While reset is high, every control output, pulse and stateOut is 0.
  - Reset mid-instruction abandons it with no writes and no instrDone.
- Control outputs are decoded from the state; every signal not listed for a state is 0.
  - FETCH: memRead=1, aluSrcB=01. irWrite and pcWrite = memReady. Go to DECODE when memReady=1, else stay.
  - DECODE: aluSrcB=11. Next state by opcode:
    - 100011/101011 → MEM_ADDR
    - 000000 → EXECUTE
    - 000100 → BRANCH
    - 000010 → JUMP
    - 001000 → ADDI_EXEC
    - other → FETCH, with illegalOp=1 this cycle.
  - MEM_ADDR: aluSrcA=1, aluSrcB=10. Go to MEM_READ if opcode=100011, else MEM_WRITE.
  - MEM_READ: memRead=1, iOrD=1. Go to MEM_WB on memReady, else stay.
  - MEM_WB: memToReg=1, regWrite=1, instrDone=1. Go to FETCH.
  - MEM_WRITE: memWrite=1, iOrD=1. On memReady: instrDone=1, go to FETCH; else stay.
  - EXECUTE: aluSrcA=1, aluOp=10. Go to R_WB.
  - R_WB: regDst=1, regWrite=1, instrDone=1. Go to FETCH.
  - BRANCH: aluSrcA=1, aluOp=01, pcSource=01, pcWriteCond=1, instrDone=1. Go to FETCH.
  - JUMP: pcSource=10, pcWrite=1, instrDone=1. Go to FETCH.
  - ADDI_EXEC: aluSrcA=1, aluSrcB=10. Go to ADDI_WB.
  - ADDI_WB: regWrite=1, instrDone=1. Go to FETCH.
- Latency with memReady always 1 (cycles FETCH→last state inclusive): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Memory wait/timeout (FETCH, MEM_READ, MEM_WRITE):
  - The wait counter clears on entering a wait state and increments each cycle memReady=0.
  - On the cycle the counter = WAIT_LIMIT-1 with memReady=0: memTimeout=1, next state FETCH, counter clears, no instrDone.
  - FETCH timing out re-enters FETCH (retry).
  - memReady=1 on the limit cycle wins: normal completion, no timeout.
- instrCount:
  - Increments on each clock edge where instrDone=1.
  - Wraps from all-ones to 0.
  - Illegal ops and aborts do not count.
- Opcode is sampled only in DECODE and MEM_ADDR; changes elsewhere are ignored.

Test Plan:
- Reset, then lw (opcode 100011), memReady=1 → states 0,1,2,3,4; regWrite=1 and memToReg=1 in cycle 5; instrDone pulse; instrCount=1.
- sw (101011) with memReady low for 3 cycles in MEM_WRITE → memWrite held 4 cycles; instrDone on the memReady cycle; no regWrite ever.
- beq with zero=1 → pcEn=1 in BRANCH. Repeat with zero=0 → pcEn=0. Both retire (instrCount +2).
- Opcode 111111 → illegalOp pulse in DECODE; FETCH next; instrCount unchanged.
- WAIT_LIMIT=4, memReady held 0 in MEM_READ → memTimeout on the 4th cycle; state 0 next; no instrDone. Then memReady=1 → normal fetch.
- Assert reset during EXECUTE → all outputs 0 immediately (asynchronous); stateOut=0 after release; instrCount=0.
